// File: rtl/t0_fetch_pkg.sv
// Shared types and the opcode length decode for the t0 byte-serial fetch engine.
package t0_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        HOLD
    } fetch_state_t;

    // Bit6 selects a payload; the length field sits just below it, MSB-aligned at bit5.
    function automatic logic [4:0] payload_len(input logic [7:0] instr, input int unsigned len_w);
        logic [5:0] field;
        field = (instr[5:0] >> (6 - len_w)) & 6'((1 << len_w) - 1);
        if (!instr[6]) begin
            return 5'd0;
        end
        return 5'(field) + 5'd1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Shift-register FIFO of assembled instructions; the head always sits in slot 0 so it is a flop.
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = logic [7:0]
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  entry_t                       push_data,
    output entry_t                       head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   wr_ptr;
    logic               do_push;
    logic               do_pop;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        do_pop  = pop & (count_q != '0);
        do_push = push & ((count_q != CNT_W'(DEPTH)) | do_pop);
        wr_ptr  = do_pop ? count_q - CNT_W'(1) : count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    mem_d[i] = mem_q[i+1];
                end
            end
            if (do_push) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (CNT_W'(i) == wr_ptr) begin
                        mem_d[i] = push_data;
                    end
                end
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign head  = mem_q[0];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/fetch_stream.sv
// Byte-serial instruction fetch: assembles opcode + payload bytes and queues whole instructions.
module fetch_stream
    import t0_fetch_pkg::*;
#(
    parameter int unsigned BYTE_W    = 8,
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned EDGE_MODE = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              byte_valid,
    input  logic [BYTE_W-1:0]                 byte_data,
    output logic                              byte_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [BYTE_W-1:0]                 out_instr,
    output logic [$clog2(MAX_BYTES):0]        out_len,
    output logic [MAX_BYTES*BYTE_W-1:0]       out_payload,
    output logic [$clog2(DEPTH+1)-1:0]        out_count,
    output logic                              overrun
);

    localparam int unsigned LEN_W = $clog2(MAX_BYTES);

    typedef struct packed {
        logic [BYTE_W-1:0]                     instr;
        logic [LEN_W:0]                        len;
        logic [0:MAX_BYTES-1][BYTE_W-1:0]      payload;
    } fetch_entry_t;

    fetch_state_t   state_q, state_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    fetch_entry_t   asm_q, asm_d;
    logic           valid_prev_q, valid_prev_d;
    logic           overrun_q, overrun_d;

    fetch_entry_t   done_entry;
    fetch_entry_t   push_entry;
    fetch_entry_t   q_head;
    logic [LEN_W:0] opc_len;
    logic           rise, accept, pop, push, complete, can_push;
    logic           q_full, q_empty;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        overrun_d    = overrun_q;
        valid_prev_d = byte_valid;
        done_entry   = asm_q;
        push_entry   = asm_q;
        push         = 1'b0;
        complete     = 1'b0;

        rise       = byte_valid & ~valid_prev_q;
        byte_ready = (state_q != HOLD) & ~flush;
        accept     = byte_ready & ((EDGE_MODE != 0) ? rise : byte_valid);
        out_valid  = ~q_empty & ~flush;
        pop        = out_valid & out_ready;
        can_push   = ~q_full | pop;
        opc_len    = (LEN_W+1)'(payload_len(byte_data[7:0], LEN_W));

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (opc_len == '0) begin
                        complete         = 1'b1;
                        done_entry       = '0;
                        done_entry.instr = byte_data;
                    end else begin
                        asm_d       = '0;
                        asm_d.instr = byte_data;
                        asm_d.len   = opc_len;
                        idx_d       = '0;
                        state_d     = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    done_entry                = asm_q;
                    done_entry.payload[idx_q] = byte_data;
                    if ((LEN_W+1)'(idx_q) == asm_q.len - (LEN_W+1)'(1)) begin
                        complete = 1'b1;
                    end else begin
                        asm_d = done_entry;
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            HOLD: begin
                if (can_push) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A finished instruction either enters the queue now or parks in HOLD.
        if (complete) begin
            if (can_push) begin
                push       = 1'b1;
                push_entry = done_entry;
                state_d    = IDLE;
            end else begin
                asm_d   = done_entry;
                state_d = HOLD;
            end
        end

        if ((EDGE_MODE != 0) && rise && !byte_ready) begin
            overrun_d = 1'b1;
        end

        if (flush) begin
            state_d   = IDLE;
            idx_d     = '0;
            push      = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            asm_q        <= '0;
            valid_prev_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            valid_prev_q <= valid_prev_d;
            overrun_q    <= overrun_d;
        end
    end

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .push_data (push_entry),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (out_count)
    );

    assign out_instr   = q_head.instr;
    assign out_len     = q_head.len;
    assign out_payload = q_head.payload;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_fetch_stream.sv
// Directed bench for fetch_stream: one level-mode and one edge-mode instance, shared clock and reset.
module tb_fetch_stream;

    logic        clk = 1'b0;
    logic        reset;

    logic        lv_flush, lv_valid, lv_brdy, lv_ovalid, lv_ordy, lv_ovr;
    logic [7:0]  lv_data, lv_instr;
    logic [2:0]  lv_len;
    logic [31:0] lv_payload;
    logic [1:0]  lv_count;

    logic        e_flush, e_valid, e_brdy, e_ovalid, e_ordy, e_ovr;
    logic [7:0]  e_data, e_instr;
    logic [2:0]  e_len;
    logic [31:0] e_payload;
    logic [1:0]  e_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stream #(.BYTE_W(8), .MAX_BYTES(4), .DEPTH(2), .EDGE_MODE(0)) u_lvl (
        .clk(clk), .reset(reset), .flush(lv_flush),
        .byte_valid(lv_valid), .byte_data(lv_data), .byte_ready(lv_brdy),
        .out_valid(lv_ovalid), .out_ready(lv_ordy), .out_instr(lv_instr),
        .out_len(lv_len), .out_payload(lv_payload), .out_count(lv_count),
        .overrun(lv_ovr)
    );

    fetch_stream #(.BYTE_W(8), .MAX_BYTES(4), .DEPTH(2), .EDGE_MODE(1)) u_edge (
        .clk(clk), .reset(reset), .flush(e_flush),
        .byte_valid(e_valid), .byte_data(e_data), .byte_ready(e_brdy),
        .out_valid(e_ovalid), .out_ready(e_ordy), .out_instr(e_instr),
        .out_len(e_len), .out_payload(e_payload), .out_count(e_count),
        .overrun(e_ovr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lv_send(input logic [7:0] b);
        lv_valid = 1'b1;
        lv_data  = b;
        step();
        lv_valid = 1'b0;
    endtask

    task automatic lv_pop();
        lv_ordy = 1'b1;
        step();
        lv_ordy = 1'b0;
    endtask

    task automatic e_pulse(input logic [7:0] b);
        e_valid = 1'b1;
        e_data  = b;
        step();
        e_valid = 1'b0;
        step();
    endtask

    task automatic e_pop();
        e_ordy = 1'b1;
        step();
        e_ordy = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        lv_flush = 0; lv_valid = 0; lv_data = 0; lv_ordy = 0;
        e_flush = 0;  e_valid = 0;  e_data = 0;  e_ordy = 0;
        step();
        step();
        check("rst_out_valid", lv_ovalid, 0);
        check("rst_out_count", lv_count, 0);
        check("rst_out_instr", lv_instr, 0);
        check("rst_out_len", lv_len, 0);
        check("rst_out_payload", lv_payload, 0);
        check("rst_overrun", lv_ovr, 0);
        check("rst_byte_ready", lv_brdy, 1);
        check("rst_edge_byte_ready", e_brdy, 1);
        reset = 1'b0;
        step();

        // len-4 instruction with latency check
        lv_send(8'h70); lv_send(8'hDE); lv_send(8'hAD); lv_send(8'hBE);
        check("len4_not_yet_valid", lv_ovalid, 0);
        lv_send(8'hEF);
        check("len4_valid", lv_ovalid, 1);
        check("len4_count", lv_count, 1);
        check("len4_instr", lv_instr, 8'h70);
        check("len4_len", lv_len, 4);
        check("len4_payload", lv_payload, 32'hDEADBEEF);
        lv_pop();
        check("len4_popped", lv_count, 0);

        // len-1 and len-0
        lv_send(8'h40); lv_send(8'h5A);
        check("len1_len", lv_len, 1);
        check("len1_payload", lv_payload, 32'h5A000000);
        lv_pop();
        lv_send(8'h12);
        check("len0_instr", lv_instr, 8'h12);
        check("len0_len", lv_len, 0);
        check("len0_payload", lv_payload, 0);
        lv_pop();
        check("len0_popped", lv_count, 0);

        // backpressure into HOLD
        lv_send(8'h40); lv_send(8'h11);
        lv_send(8'h40); lv_send(8'h22);
        check("bp_count2", lv_count, 2);
        lv_send(8'h40); lv_send(8'h33);
        check("hold_count", lv_count, 2);
        check("hold_byte_ready", lv_brdy, 0);
        check("hold_head", lv_payload, 32'h11000000);
        lv_pop();
        check("hold_exit_count", lv_count, 2);
        check("hold_exit_ready", lv_brdy, 1);
        check("fifo_order_2", lv_payload, 32'h22000000);
        lv_pop();
        check("fifo_order_3", lv_payload, 32'h33000000);
        check("fifo_count_1", lv_count, 1);
        lv_pop();
        check("fifo_empty", lv_count, 0);

        // flush mid-assembly with an entry queued
        lv_send(8'h12);
        lv_send(8'h70); lv_send(8'hAA); lv_send(8'hBB);
        check("pre_flush_count", lv_count, 1);
        lv_flush = 1'b1;
        #1;
        check("flush_gates_valid", lv_ovalid, 0);
        check("flush_gates_ready", lv_brdy, 0);
        step();
        lv_flush = 1'b0;
        check("flush_count", lv_count, 0);
        check("flush_valid", lv_ovalid, 0);
        lv_send(8'h00);
        check("post_flush_valid", lv_ovalid, 1);
        check("post_flush_instr", lv_instr, 8'h00);
        check("post_flush_len", lv_len, 0);
        lv_pop();

        // asynchronous reset mid-payload
        lv_send(8'h12);
        lv_send(8'h70); lv_send(8'h01);
        #2;
        reset = 1'b1;
        #1;
        check("amid_rst_count", lv_count, 0);
        check("amid_rst_valid", lv_ovalid, 0);
        check("amid_rst_instr", lv_instr, 0);
        check("amid_rst_ready", lv_brdy, 1);
        step();
        reset = 1'b0;
        lv_send(8'h40); lv_send(8'h77);
        check("post_rst_instr", lv_instr, 8'h40);
        check("post_rst_payload", lv_payload, 32'h77000000);
        check("post_rst_count", lv_count, 1);

        // edge mode: held valid is a single byte
        e_valid = 1'b1;
        e_data  = 8'h12;
        step(); step(); step();
        e_valid = 1'b0;
        step();
        check("edge_one_byte", e_count, 1);
        check("edge_instr", e_instr, 8'h12);
        check("edge_no_ovr", e_ovr, 0);
        e_pulse(8'h12);
        check("edge_count2", e_count, 2);
        e_pulse(8'h12);
        check("edge_hold_ready", e_brdy, 0);
        e_pulse(8'h55);
        check("edge_overrun", e_ovr, 1);
        check("edge_hold_count", e_count, 2);
        e_pop();
        check("edge_hold_exit_count", e_count, 2);
        check("edge_hold_exit_ready", e_brdy, 1);
        e_pop();
        e_pop();
        check("edge_drained", e_count, 0);
        e_pulse(8'h12);
        check("edge_lost_byte", e_count, 1);
        check("edge_ovr_sticky", e_ovr, 1);
        e_flush = 1'b1;
        step();
        e_flush = 1'b0;
        check("edge_flush_ovr", e_ovr, 0);
        check("edge_flush_count", e_count, 0);
        check("level_never_ovr", lv_ovr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
